// File: rtl/muldiv_if.sv
// muldiv_if: request/response bundle between the pipeline and the multiply/divide unit
interface muldiv_if #(parameter int WIDTH = 32);
  logic             start;
  logic [2:0]       ALUOp;
  logic [5:0]       func;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             illegal;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  modport master (output start, ALUOp, func, a, b, input busy, done, illegal, result, hi, lo);
  modport slave (input start, ALUOp, func, a, b, output busy, done, illegal, result, hi, lo);
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MIPS HI/LO multiply/divide unit with MFHI/MFLO/MTHI/MTLO
module muldiv_unit #(parameter int WIDTH = 32) (
  input logic clk,
  input logic rst,
  muldiv_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic is_div, neg_q, neg_r, zero_div;
  logic [WIDTH-1:0] mc, p_hi, p_lo;
  logic r_type, op_mfhi, op_mthi, op_mflo, op_mtlo, op_mult, op_multu, op_div, op_divu;
  logic op_long, legal, sa, sb;
  logic [WIDTH-1:0] abs_a, abs_b, q_fix, r_fix;
  logic [WIDTH:0] msum, dshift, dtrial;
  logic [2*WIDTH-1:0] mshift, prod_fix;
  always_comb begin
    r_type   = bus.ALUOp == 3'b010;
    op_mfhi  = r_type && bus.func == 6'b010000;
    op_mthi  = r_type && bus.func == 6'b010001;
    op_mflo  = r_type && bus.func == 6'b010010;
    op_mtlo  = r_type && bus.func == 6'b010011;
    op_mult  = r_type && bus.func == 6'b011000;
    op_multu = r_type && bus.func == 6'b011001;
    op_div   = r_type && bus.func == 6'b011010;
    op_divu  = r_type && bus.func == 6'b011011;
    op_long  = op_mult | op_multu | op_div | op_divu;
    legal    = op_long | op_mfhi | op_mthi | op_mflo | op_mtlo;
    sa       = (op_mult | op_div) & bus.a[WIDTH-1];
    sb       = (op_mult | op_div) & bus.b[WIDTH-1];
    abs_a    = sa ? -bus.a : bus.a;
    abs_b    = sb ? -bus.b : bus.b;
    // multiply: p_lo holds the multiplier, shifted out LSB first while the product grows in from the top
    msum     = {1'b0, p_hi} + (p_lo[0] ? {1'b0, mc} : '0);
    mshift   = {msum, p_lo[WIDTH-1:1]};
    // divide: p_hi is the partial remainder, p_lo shifts dividend bits out and quotient bits in
    dshift   = {p_hi, p_lo[WIDTH-1]};
    dtrial   = dshift - {1'b0, mc};
    prod_fix = neg_q ? -{p_hi, p_lo} : {p_hi, p_lo};
    q_fix    = zero_div ? '1 : neg_q ? -p_lo : p_lo;
    r_fix    = neg_r ? -p_hi : p_hi;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      zero_div    <= 1'b0;
      mc          <= '0;
      p_hi        <= '0;
      p_lo        <= '0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.illegal <= 1'b0;
      bus.result  <= '0;
      bus.hi      <= '0;
      bus.lo      <= '0;
    end else begin
      bus.done    <= 1'b0;
      bus.illegal <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          if (!legal) bus.illegal <= 1'b1;
          else if (op_long) begin
            state    <= RUN;
            bus.busy <= 1'b1;
            cnt      <= CW'(WIDTH);
            is_div   <= op_div | op_divu;
            neg_q    <= sa ^ sb;
            neg_r    <= sa;
            zero_div <= bus.b == '0;
            mc       <= abs_b;
            p_hi     <= '0;
            p_lo     <= abs_a;
          end else begin
            bus.done <= 1'b1;
            if (op_mthi) bus.hi <= bus.a;
            if (op_mtlo) bus.lo <= bus.a;
            if (op_mfhi) bus.result <= bus.hi;
            if (op_mflo) bus.result <= bus.lo;
          end
        end
        RUN: begin
          if (is_div) begin
            p_hi <= dtrial[WIDTH] ? dshift[WIDTH-1:0] : dtrial[WIDTH-1:0];
            p_lo <= {p_lo[WIDTH-2:0], ~dtrial[WIDTH]};
          end else {p_hi, p_lo} <= mshift;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= FIX;
        end
        FIX: begin
          bus.hi   <= is_div ? r_fix : prod_fix[2*WIDTH-1:WIDTH];
          bus.lo   <= is_div ? q_fix : prod_fix[WIDTH-1:0];
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors checked cycle by cycle against an arithmetic HI/LO model
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic on = 1'b0;
  int total = 0;
  int pass = 0;
  muldiv_if #(.WIDTH(32)) bus();
  muldiv_unit #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  logic [31:0] m_hi, m_lo, m_res, n_hi, n_lo;
  logic m_busy, m_done, m_ill;
  int pend;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask
  function automatic logic [63:0] calc(input logic [5:0] fn, input logic [31:0] x, input logic [31:0] y);
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    logic [63:0] ux = {32'b0, x};
    logic [63:0] uy = {32'b0, y};
    case (fn)
      6'b011000: return 64'(sx * sy);
      6'b011001: return ux * uy;
      6'b011010: return y == 0 ? {x, 32'hFFFFFFFF} : {32'(sx % sy), 32'(sx / sy)};
      default:   return y == 0 ? {x, 32'hFFFFFFFF} : {32'(ux % uy), 32'(ux / uy)};
    endcase
  endfunction
  always @(posedge clk) begin
    m_done <= 1'b0;
    m_ill  <= 1'b0;
    if (rst) begin
      {m_hi, m_lo, m_res, m_busy, pend} <= '0;
    end else if (pend > 0) begin
      pend <= pend - 1;
      if (pend == 1) begin
        m_hi <= n_hi;
        m_lo <= n_lo;
        m_done <= 1'b1;
        m_busy <= 1'b0;
      end
    end else if (bus.start) begin
      if (bus.ALUOp != 3'b010) m_ill <= 1'b1;
      else case (bus.func)
        6'b010000: begin m_res <= m_hi; m_done <= 1'b1; end
        6'b010001: begin m_hi <= bus.a; m_done <= 1'b1; end
        6'b010010: begin m_res <= m_lo; m_done <= 1'b1; end
        6'b010011: begin m_lo <= bus.a; m_done <= 1'b1; end
        6'b011000, 6'b011001, 6'b011010, 6'b011011: begin
          {n_hi, n_lo} <= calc(bus.func, bus.a, bus.b);
          m_busy <= 1'b1;
          pend <= 33;
        end
        default: m_ill <= 1'b1;
      endcase
    end
  end
  always @(negedge clk) if (on) begin
    chk("busy", 32'(bus.busy), 32'(m_busy));
    chk("done", 32'(bus.done), 32'(m_done));
    chk("illegal", 32'(bus.illegal), 32'(m_ill));
    chk("hi", bus.hi, m_hi);
    chk("lo", bus.lo, m_lo);
    chk("result", bus.result, m_res);
  end
  task automatic op_now(input logic [2:0] al, input logic [5:0] fn, input logic [31:0] x, input logic [31:0] y);
    bus.start = 1'b1;
    bus.ALUOp = al;
    bus.func = fn;
    bus.a = x;
    bus.b = y;
    @(negedge clk);
    bus.start = 1'b0;
  endtask
  task automatic op(input logic [2:0] al, input logic [5:0] fn, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    op_now(al, fn, x, y);
  endtask
  task automatic wait_done(output int n);
    n = 0;
    while (!bus.done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("wait_done", 32'(bus.done), 32'd1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n;
    {bus.start, bus.ALUOp, bus.func, bus.a, bus.b} = '0;
    repeat (2) @(negedge clk);
    on = 1'b1;
    chk("rst_hi", bus.hi, 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    rst = 1'b0;
    op(3'b010, 6'b011000, 32'hFFFFFFFD, 32'd7);
    chk("mult_busy", 32'(bus.busy), 32'h1);
    wait_done(n);
    chk("mult_lat", 32'(n), 32'd33);
    chk("mult_hi", bus.hi, 32'hFFFFFFFF);
    chk("mult_lo", bus.lo, 32'hFFFFFFEB);
    @(negedge clk);
    chk("mult_done_1cyc", 32'(bus.done), 32'h0);
    op(3'b010, 6'b011001, 32'hFFFFFFFD, 32'd7);
    wait_done(n);
    chk("multu_hi", bus.hi, 32'h00000006);
    chk("multu_lo", bus.lo, 32'hFFFFFFEB);
    op(3'b010, 6'b011010, 32'hFFFFFFF9, 32'd2);
    wait_done(n);
    chk("div_lo", bus.lo, 32'hFFFFFFFD);
    chk("div_hi", bus.hi, 32'hFFFFFFFF);
    op(3'b010, 6'b011010, 32'h80000000, 32'hFFFFFFFF);
    wait_done(n);
    chk("divovf_lo", bus.lo, 32'h80000000);
    chk("divovf_hi", bus.hi, 32'h0);
    op(3'b010, 6'b011011, 32'h12345678, 32'h0);
    wait_done(n);
    chk("div0_lat", 32'(n), 32'd33);
    chk("div0_lo", bus.lo, 32'hFFFFFFFF);
    chk("div0_hi", bus.hi, 32'h12345678);
    op(3'b010, 6'b010001, 32'hA5A5A5A5, 32'h0);
    chk("mthi_hi", bus.hi, 32'hA5A5A5A5);
    chk("mthi_done", 32'(bus.done), 32'h1);
    op(3'b010, 6'b010000, 32'h0, 32'h0);
    chk("mfhi_res", bus.result, 32'hA5A5A5A5);
    op(3'b010, 6'b011000, 32'd3, 32'd5);
    op(3'b010, 6'b010011, 32'h1, 32'h0);
    wait_done(n);
    chk("mult35_lo", bus.lo, 32'd15);
    chk("mult35_hi", bus.hi, 32'd0);
    op_now(3'b010, 6'b011011, 32'd100, 32'd7);
    wait_done(n);
    chk("b2b_lat", 32'(n), 32'd33);
    chk("divu_lo", bus.lo, 32'd14);
    chk("divu_hi", bus.hi, 32'd2);
    op(3'b010, 6'b011000, 32'h7FFFFFFF, 32'd2);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(bus.busy), 32'h0);
    chk("abort_lo", bus.lo, 32'h0);
    repeat (40) @(negedge clk);
    op(3'b010, 6'b011001, 32'd6, 32'd7);
    wait_done(n);
    chk("multu42_lo", bus.lo, 32'd42);
    chk("multu42_hi", bus.hi, 32'd0);
    op(3'b000, 6'b011000, 32'd9, 32'd9);
    chk("ill1", 32'(bus.illegal), 32'h1);
    op(3'b010, 6'b011100, 32'd9, 32'd9);
    chk("ill2", 32'(bus.illegal), 32'h1);
    chk("ill2_done", 32'(bus.done), 32'h0);
    chk("ill2_lo", bus.lo, 32'd42);
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
